// File: rtl/hazard_controller.sv
// Pipeline hazard controller: EX/MEM/WB destination scoreboard, operand
// bypass selects, load-use and multi-cycle-EX stall sequencing.
//
// Ports:
//   clk, rst              core clock, async active-high reset
//   dec*                  decode-stage instruction fields
//   exBusy                multi-cycle EX unit occupied (freeze)
//   isBranchPredictMiss   1-cycle flush pulse from EX
//   isDataHazard          stall fetch/decode this cycle
//   op1/op2BypassCtrl     0 RF, 1 EX, 2 MEM, 3 WB producer
//   stateOut              FSM state (0 RUN, 1 LU_STALL, 2 EX_HOLD)
//
// Build option HAZARD_CTRL_PERF_CNT_EN adds stallCycles and flushCount
// saturating counters.
module hazard_controller #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SB     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  decValid,
  input  logic [REG_ADDR_W-1:0] decRs1Addr,
  input  logic [REG_ADDR_W-1:0] decRs2Addr,
  input  logic                  decRs1Used,
  input  logic                  decRs2Used,
  input  logic [REG_ADDR_W-1:0] decRdAddr,
  input  logic                  decWEnable,
  input  logic                  decIsLoad,
  input  logic                  exBusy,
  input  logic                  isBranchPredictMiss,
  output logic                  isDataHazard,
  output logic [1:0]            op1BypassCtrl,
  output logic [1:0]            op2BypassCtrl,
  output logic [1:0]            stateOut
`ifdef HAZARD_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]           stallCycles,
  output logic [31:0]           flushCount
`endif
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wen;
    logic                  is_load;
  } sb_entry_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    EX_HOLD  = 2'd2
  } state_t;

  // index 0 = EX, 1 = MEM, 2 = WB
  sb_entry_t sb [NUM_SB];
  sb_entry_t dec_entry;
  state_t    state;

  logic load_use;
  logic miss_ok;

  function automatic logic hit(
    input sb_entry_t             e,
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  used
  );
    return e.valid && e.wen && (e.rd != '0)
      && (e.rd == rs) && used;
  endfunction

  // Scan oldest to youngest so the youngest producer wins.
  always_comb begin
    op1BypassCtrl = 2'd0;
    op2BypassCtrl = 2'd0;
    for (int i = NUM_SB - 1; i >= 0; i--) begin
      if (hit(sb[i], decRs1Addr, decRs1Used))
        op1BypassCtrl = 2'(i + 1);
      if (hit(sb[i], decRs2Addr, decRs2Used))
        op2BypassCtrl = 2'(i + 1);
    end
  end

  always_comb begin
    load_use = sb[0].is_load
      && (hit(sb[0], decRs1Addr, decRs1Used)
       || hit(sb[0], decRs2Addr, decRs2Used));
    // A flush kills the dependent decode, so it overrides load-use.
    // Reset masks the busy input so outputs clear without a clock.
    isDataHazard = !rst
      && (exBusy || (load_use && !isBranchPredictMiss));
    // Miss during a freeze is dropped; EX re-presents it later.
    miss_ok = isBranchPredictMiss && !exBusy;
  end

  always_comb begin
    dec_entry.valid   = decValid && !isDataHazard
                     && !isBranchPredictMiss;
    dec_entry.rd      = decRdAddr;
    dec_entry.wen     = decWEnable;
    dec_entry.is_load = decIsLoad;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SB; i++)
        sb[i] <= '0;
    end else if (!exBusy) begin
      sb[0] <= dec_entry;
      for (int i = 1; i < NUM_SB; i++)
        sb[i] <= sb[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      unique case (state)
        RUN, LU_STALL: begin
          if (exBusy)
            state <= EX_HOLD;
          else if (isBranchPredictMiss)
            state <= RUN;
          else if (load_use)
            state <= LU_STALL;
          else
            state <= RUN;
        end
        EX_HOLD: begin
          if (exBusy)
            state <= EX_HOLD;
          else
            state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  assign stateOut = state;

`ifdef HAZARD_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCycles <= '0;
      flushCount  <= '0;
    end else begin
      if (isDataHazard && (stallCycles != '1))
        stallCycles <= stallCycles + 32'd1;
      if (miss_ok && (flushCount != '1))
        flushCount <= flushCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios plus
// random traffic against a queue-based pipeline model.
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       decValid;
  logic [4:0] decRs1Addr;
  logic [4:0] decRs2Addr;
  logic       decRs1Used;
  logic       decRs2Used;
  logic [4:0] decRdAddr;
  logic       decWEnable;
  logic       decIsLoad;
  logic       exBusy;
  logic       isBranchPredictMiss;
  logic       isDataHazard;
  logic [1:0] op1BypassCtrl;
  logic [1:0] op2BypassCtrl;
  logic [1:0] stateOut;
`ifdef HAZARD_CTRL_PERF_CNT_EN
  logic [31:0] stallCycles;
  logic [31:0] flushCount;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  hazard_controller dut (
    .clk                 (clk),
    .rst                 (rst),
    .decValid            (decValid),
    .decRs1Addr          (decRs1Addr),
    .decRs2Addr          (decRs2Addr),
    .decRs1Used          (decRs1Used),
    .decRs2Used          (decRs2Used),
    .decRdAddr           (decRdAddr),
    .decWEnable          (decWEnable),
    .decIsLoad           (decIsLoad),
    .exBusy              (exBusy),
    .isBranchPredictMiss (isBranchPredictMiss),
    .isDataHazard        (isDataHazard),
    .op1BypassCtrl       (op1BypassCtrl),
    .op2BypassCtrl       (op2BypassCtrl),
    .stateOut            (stateOut)
`ifdef HAZARD_CTRL_PERF_CNT_EN
    ,
    .stallCycles         (stallCycles),
    .flushCount          (flushCount)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // pipe[0] = EX, pipe[1] = MEM, pipe[2] = WB
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       we;
    bit       ld;
  } ent_t;

  ent_t        pipe[$];
  int          m_state;
  int unsigned m_stalls;
  int unsigned m_flushes;

  function automatic int m_sel(bit [4:0] rs, bit used);
    for (int a = 0; a < pipe.size(); a++)
      if (used && pipe[a].v && pipe[a].we
          && pipe[a].rd != 0 && pipe[a].rd == rs)
        return a + 1;
    return 0;
  endfunction

  function automatic bit m_lu();
    return pipe[0].ld
      && (m_sel(decRs1Addr, decRs1Used) == 1
       || m_sel(decRs2Addr, decRs2Used) == 1);
  endfunction

  function automatic bit m_haz();
    return exBusy || (m_lu() && !isBranchPredictMiss);
  endfunction

  task automatic model_reset();
    ent_t e;
    e = '{v: 0, rd: 0, we: 0, ld: 0};
    pipe.delete();
    for (int i = 0; i < 3; i++) pipe.push_back(e);
    m_state   = 0;
    m_stalls  = 0;
    m_flushes = 0;
  endtask

  // Advance the model by one clock using the inputs now applied.
  task automatic model_step();
    ent_t ne;
    bit   haz;
    bit   lu;
    if (rst) begin
      model_reset();
      return;
    end
    haz = m_haz();
    lu  = m_lu();
    if (haz && m_stalls != 32'hFFFF_FFFF) m_stalls++;
    if (isBranchPredictMiss && !exBusy
        && m_flushes != 32'hFFFF_FFFF) m_flushes++;
    if (exBusy)                   m_state = 2;
    else if (m_state == 2)        m_state = 0;
    else if (isBranchPredictMiss) m_state = 0;
    else if (lu)                  m_state = 1;
    else                          m_state = 0;
    if (!exBusy) begin
      ne.v  = decValid && !haz && !isBranchPredictMiss;
      ne.rd = decRdAddr;
      ne.we = decWEnable;
      ne.ld = decIsLoad;
      pipe.push_front(ne);
      void'(pipe.pop_back());
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(
    input bit       v,
    input bit [4:0] rs1,
    input bit       u1,
    input bit [4:0] rs2,
    input bit       u2,
    input bit [4:0] rd,
    input bit       we,
    input bit       ld
  );
    decValid   = v;
    decRs1Addr = rs1;
    decRs1Used = u1;
    decRs2Addr = rs2;
    decRs2Used = u2;
    decRdAddr  = rd;
    decWEnable = we;
    decIsLoad  = ld;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    exBusy = 1'b1;
    set_dec(1, 5, 1, 6, 1, 5, 1, 0);
    #1;
    n_checks++;
    if (isDataHazard !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_haz got=%b exp=0", isDataHazard);
    end
    n_checks++;
    if (op1BypassCtrl !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_op1 got=%0d exp=0", op1BypassCtrl);
    end
    n_checks++;
    if (op2BypassCtrl !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_op2 got=%0d exp=0", op2BypassCtrl);
    end
    n_checks++;
    if (stateOut !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state got=%0d exp=0", stateOut);
    end
    #1;
    rst = 1'b0;
    exBusy = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
  endtask

  task automatic test_back_to_back();
    set_dec(1, 1, 1, 2, 1, 5, 1, 0);
    cyc();
    set_dec(1, 5, 1, 0, 0, 0, 0, 0);
    #1;
    n_checks++;
    if (op1BypassCtrl !== 2'd1 || isDataHazard !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ex got op1=%0d haz=%b exp op1=1 haz=0",
               op1BypassCtrl, isDataHazard);
    end
    cyc();
    set_dec(1, 0, 0, 5, 1, 0, 0, 0);
    #1;
    n_checks++;
    if (op2BypassCtrl !== 2'd2) begin
      n_fail++;
      $display("FAIL b2b_mem got=%0d exp=2", op2BypassCtrl);
    end
    cyc();
    #1;
    n_checks++;
    if (op2BypassCtrl !== 2'd3) begin
      n_fail++;
      $display("FAIL b2b_wb got=%0d exp=3", op2BypassCtrl);
    end
    cyc();
    #1;
    n_checks++;
    if (op2BypassCtrl !== 2'd0) begin
      n_fail++;
      $display("FAIL b2b_retired got=%0d exp=0", op2BypassCtrl);
    end
  endtask

  task automatic test_load_use();
    set_dec(1, 0, 0, 0, 0, 7, 1, 1);
    cyc();
    set_dec(1, 0, 0, 7, 1, 8, 1, 0);
    #1;
    n_checks++;
    if (isDataHazard !== 1'b1 || stateOut !== 2'd0) begin
      n_fail++;
      $display("FAIL lu_detect got haz=%b st=%0d exp haz=1 st=0",
               isDataHazard, stateOut);
    end
    cyc();
    #1;
    n_checks++;
    if (isDataHazard !== 1'b0 || stateOut !== 2'd1
        || op2BypassCtrl !== 2'd2) begin
      n_fail++;
      $display("FAIL lu_release got haz=%b st=%0d op2=%0d exp 0/1/2",
               isDataHazard, stateOut, op2BypassCtrl);
    end
    cyc();
    set_dec(1, 8, 1, 7, 1, 0, 0, 0);
    #1;
    n_checks++;
    if (stateOut !== 2'd0 || op1BypassCtrl !== 2'd1
        || op2BypassCtrl !== 2'd3) begin
      n_fail++;
      $display("FAIL lu_after got st=%0d op1=%0d op2=%0d exp 0/1/3",
               stateOut, op1BypassCtrl, op2BypassCtrl);
    end
    cyc();
  endtask

  task automatic test_x0_priority();
    set_dec(1, 0, 0, 0, 0, 3, 1, 0);
    cyc();
    set_dec(1, 0, 0, 0, 0, 0, 1, 0);
    cyc();
    set_dec(1, 0, 0, 0, 0, 3, 1, 0);
    cyc();
    set_dec(1, 0, 1, 3, 1, 0, 0, 0);
    #1;
    n_checks++;
    if (op1BypassCtrl !== 2'd0) begin
      n_fail++;
      $display("FAIL x0_op1 got=%0d exp=0", op1BypassCtrl);
    end
    n_checks++;
    if (op2BypassCtrl !== 2'd1) begin
      n_fail++;
      $display("FAIL prio_op2 got=%0d exp=1", op2BypassCtrl);
    end
    set_dec(1, 3, 0, 3, 1, 0, 0, 0);
    #1;
    n_checks++;
    if (op1BypassCtrl !== 2'd0) begin
      n_fail++;
      $display("FAIL unused_op1 got=%0d exp=0", op1BypassCtrl);
    end
    set_dec(0, 0, 0, 0, 0, 9, 1, 0);
    cyc();
    set_dec(1, 9, 1, 3, 1, 0, 0, 0);
    #1;
    n_checks++;
    if (op1BypassCtrl !== 2'd0 || op2BypassCtrl !== 2'd2) begin
      n_fail++;
      $display("FAIL invalid_dec got op1=%0d op2=%0d exp 0/2",
               op1BypassCtrl, op2BypassCtrl);
    end
    cyc();
  endtask

  task automatic test_ex_hold();
    set_dec(1, 0, 0, 0, 0, 10, 1, 0);
    cyc();
    set_dec(1, 0, 0, 0, 0, 11, 1, 0);
    cyc();
    set_dec(1, 0, 0, 0, 0, 12, 1, 0);
    cyc();
    set_dec(1, 12, 1, 10, 1, 0, 0, 0);
    exBusy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++;
      if (isDataHazard !== 1'b1 || op1BypassCtrl !== 2'd1
          || op2BypassCtrl !== 2'd3
          || stateOut !== ((k == 0) ? 2'd0 : 2'd2)) begin
        n_fail++;
        $display("FAIL hold_%0d got haz=%b op1=%0d op2=%0d st=%0d",
                 k, isDataHazard, op1BypassCtrl, op2BypassCtrl,
                 stateOut);
      end
      cyc();
    end
    exBusy = 1'b0;
    #1;
    n_checks++;
    if (isDataHazard !== 1'b0 || stateOut !== 2'd2
        || op1BypassCtrl !== 2'd1 || op2BypassCtrl !== 2'd3) begin
      n_fail++;
      $display("FAIL hold_exit got haz=%b st=%0d op1=%0d op2=%0d",
               isDataHazard, stateOut, op1BypassCtrl, op2BypassCtrl);
    end
    cyc();
    #1;
    n_checks++;
    if (stateOut !== 2'd0 || op1BypassCtrl !== 2'd2
        || op2BypassCtrl !== 2'd0) begin
      n_fail++;
      $display("FAIL hold_shift got st=%0d op1=%0d op2=%0d exp 0/2/0",
               stateOut, op1BypassCtrl, op2BypassCtrl);
    end
    cyc();
  endtask

  task automatic test_branch_vs_load_use();
    set_dec(1, 0, 0, 0, 0, 9, 1, 1);
    cyc();
    set_dec(1, 9, 1, 0, 0, 20, 1, 0);
    isBranchPredictMiss = 1'b1;
    #1;
    n_checks++;
    if (isDataHazard !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_lu_haz got=%b exp=0", isDataHazard);
    end
    cyc();
    isBranchPredictMiss = 1'b0;
    set_dec(1, 9, 1, 20, 1, 0, 0, 0);
    #1;
    n_checks++;
    if (isDataHazard !== 1'b0 || stateOut !== 2'd0
        || op1BypassCtrl !== 2'd2 || op2BypassCtrl !== 2'd0) begin
      n_fail++;
      $display("FAIL miss_flush got haz=%b st=%0d op1=%0d op2=%0d",
               isDataHazard, stateOut, op1BypassCtrl, op2BypassCtrl);
    end
`ifdef HAZARD_CTRL_PERF_CNT_EN
    n_checks++;
    if (flushCount !== m_flushes) begin
      n_fail++;
      $display("FAIL flush_cnt got=%0d exp=%0d", flushCount, m_flushes);
    end
    n_checks++;
    if (stallCycles !== m_stalls) begin
      n_fail++;
      $display("FAIL stall_cnt got=%0d exp=%0d", stallCycles, m_stalls);
    end
`endif
    cyc();
  endtask

  task automatic test_async_reset();
    set_dec(1, 0, 0, 0, 0, 13, 1, 0);
    cyc();
    set_dec(1, 0, 0, 0, 0, 14, 1, 0);
    cyc();
    set_dec(1, 0, 0, 0, 0, 15, 1, 0);
    cyc();
    set_dec(1, 15, 1, 14, 1, 0, 0, 0);
    exBusy = 1'b1;
    cyc();
    cyc();
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (isDataHazard !== 1'b0 || op1BypassCtrl !== 2'd0
        || op2BypassCtrl !== 2'd0 || stateOut !== 2'd0) begin
      n_fail++;
      $display("FAIL async_rst got haz=%b op1=%0d op2=%0d st=%0d",
               isDataHazard, op1BypassCtrl, op2BypassCtrl, stateOut);
    end
`ifdef HAZARD_CTRL_PERF_CNT_EN
    n_checks++;
    if (stallCycles !== 32'd0 || flushCount !== 32'd0) begin
      n_fail++;
      $display("FAIL async_rst_cnt got stall=%0d flush=%0d exp 0/0",
               stallCycles, flushCount);
    end
`endif
    #1;
    rst = 1'b0;
    exBusy = 1'b0;
    #1;
    n_checks++;
    if (op1BypassCtrl !== 2'd0 || isDataHazard !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst got op1=%0d haz=%b exp 0/0",
               op1BypassCtrl, isDataHazard);
    end
    cyc();
  endtask

  task automatic test_random();
    int errs;
    int e1;
    int e2;
    errs = 0;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      set_dec($urandom_range(0, 9) < 8,
              5'($urandom_range(0, 7)), 1'($urandom),
              5'($urandom_range(0, 7)), 1'($urandom),
              5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
              $urandom_range(0, 9) < 3);
      exBusy = $urandom_range(0, 9) == 0;
      isBranchPredictMiss = $urandom_range(0, 19) == 0;
      #1;
      e1 = m_sel(decRs1Addr, decRs1Used);
      e2 = m_sel(decRs2Addr, decRs2Used);
      n_checks++;
      if (isDataHazard !== m_haz() || op1BypassCtrl !== 2'(e1)
          || op2BypassCtrl !== 2'(e2) || stateOut !== 2'(m_state)) begin
        n_fail++;
        errs++;
        if (errs < 10)
          $display("FAIL rand_%0d got %b/%0d/%0d/%0d exp %b/%0d/%0d/%0d",
                   n, isDataHazard, op1BypassCtrl, op2BypassCtrl,
                   stateOut, m_haz(), e1, e2, m_state);
      end
      cyc();
    end
`ifdef HAZARD_CTRL_PERF_CNT_EN
    n_checks++;
    if (stallCycles !== m_stalls || flushCount !== m_flushes) begin
      n_fail++;
      $display("FAIL rand_cnt got %0d/%0d exp %0d/%0d",
               stallCycles, flushCount, m_stalls, m_flushes);
    end
`endif
    exBusy = 1'b0;
    isBranchPredictMiss = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    exBusy = 1'b0;
    isBranchPredictMiss = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    test_reset();
    test_back_to_back();
    test_load_use();
    test_x0_priority();
    test_ex_hold();
    test_branch_vs_load_use();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
